sext_arbiter: RTL and testbench

//  Shares the single 3->8 bit sign-extension unit between two requesters
//  (req0: decode/ALU immediate path, req1: branch-offset path). Arbitrates,

---
 rtl/sext_arbiter.sv | 82 ++++++++
 tb/tb_sext_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/sext_arbiter.sv
// sext_arbiter: shares one 3->8 sign-extension unit between two requesters,
// registering the result and returning it over a per-requester valid/ready channel.
module sext_arbiter #(
   parameter int FIELD_W       = 3,
   parameter int DATA_W        = 8,
   parameter int PRIORITY_MODE = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic [FIELD_W-1:0] req0_field,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [FIELD_W-1:0] req1_field,
   output logic               req1_ready,
   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic [FIELD_W-1:0] sext_in,
   input  logic [DATA_W-1:0]  sext_out,
   output logic               busy,
   output logic               ext_err
);
   typedef enum logic [1:0] {IDLE, EXT, RESP} state_t;
   state_t state_q, state_d;
   logic rr_ptr_q, rr_ptr_d, owner_q, owner_d, ext_err_q, ext_err_d;
   logic [FIELD_W-1:0] field_q, field_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic grant, win, bad;
   always_comb begin
      win = (req0_valid && req1_valid) ? ((PRIORITY_MODE != 0) ? 1'b0 : rr_ptr_q) : !req0_valid;
      grant = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
      bad = (sext_out[DATA_W-1:FIELD_W] != {(DATA_W-FIELD_W){field_q[FIELD_W-1]}}) ||
            (sext_out[FIELD_W-1:0] != field_q);
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d = owner_q;
      field_d = field_q;
      rsp_data_d = rsp_data_q;
      ext_err_d = ext_err_q;
      if (grant) begin
         state_d = EXT;
         field_d = win ? req1_field : req0_field;
         owner_d = win;
         rr_ptr_d = !win;
      end
      if (state_q == EXT) begin
         state_d = RESP;
         rsp_data_d = sext_out;
         ext_err_d = ext_err_q | bad;
      end
      if (state_q == RESP && (owner_q ? rsp1_ready : rsp0_ready)) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_ptr_q <= 1'b0;
         owner_q <= 1'b0;
         field_q <= '0;
         rsp_data_q <= '0;
         ext_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q <= owner_d;
         field_q <= field_d;
         rsp_data_q <= rsp_data_d;
         ext_err_q <= ext_err_d;
      end
   end
   // ready is gated by rst so nothing is acknowledged while reset is held
   assign req0_ready = grant && !win;
   assign req1_ready = grant && win;
   assign rsp0_valid = (state_q == RESP) && !owner_q;
   assign rsp1_valid = (state_q == RESP) && owner_q;
   assign rsp_data = rsp_data_q;
   assign sext_in = field_q;
   assign busy = state_q != IDLE;
   assign ext_err = ext_err_q;
endmodule

// File: tb/tb_sext_arbiter.sv
// tb_sext_arbiter: table-driven check of the sign-extension arbiter in round-robin
// mode with a fixed-priority instance alongside, plus hand-written stall/error/reset sequences.
module tb_sext_arbiter;
   logic clk = 1'b0;
   logic rst, v0, v1, r0, r1, bad_mode;
   logic [2:0] f0, f1, sext_in, p_sext_in;
   logic [7:0] sext_out, p_sext_out, rsp_data, p_data;
   logic rdy0, rdy1, rv0, rv1, busy, err;
   logic p_rdy0, p_rdy1, p_rv0, p_rv1, p_busy, p_err;
   int n_vec = 0, n_bad = 0;
   always #5 clk = ~clk;
   assign sext_out = (bad_mode && sext_in == 3'b101) ? 8'h05 : {{5{sext_in[2]}}, sext_in};
   assign p_sext_out = {{5{p_sext_in[2]}}, p_sext_in};
   sext_arbiter #(.PRIORITY_MODE(0)) dut (
      .clk(clk), .rst(rst), .req0_valid(v0), .req0_field(f0), .req0_ready(rdy0),
      .req1_valid(v1), .req1_field(f1), .req1_ready(rdy1), .rsp0_valid(rv0), .rsp0_ready(r0),
      .rsp1_valid(rv1), .rsp1_ready(r1), .rsp_data(rsp_data), .sext_in(sext_in),
      .sext_out(sext_out), .busy(busy), .ext_err(err));
   sext_arbiter #(.PRIORITY_MODE(1)) dut_p (
      .clk(clk), .rst(rst), .req0_valid(v0), .req0_field(f0), .req0_ready(p_rdy0),
      .req1_valid(v1), .req1_field(f1), .req1_ready(p_rdy1), .rsp0_valid(p_rv0), .rsp0_ready(r0),
      .rsp1_valid(p_rv1), .rsp1_ready(r1), .rsp_data(p_data), .sext_in(p_sext_in),
      .sext_out(p_sext_out), .busy(p_busy), .ext_err(p_err));
   typedef struct {
      logic rst, v0; logic [2:0] f0; logic v1; logic [2:0] f1; logic r0, r1;
      logic [1:0] rdy, rv; logic [7:0] data; logic [2:0] sin; logic busy, err;
      logic [1:0] prdy; logic [7:0] pdata;
   } vec_t;
   vec_t tbl[$];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic cyc(input logic rs, input logic a0, input logic [2:0] b0, input logic a1,
                      input logic [2:0] b1, input logic c0, input logic c1, input logic bm);
      @(negedge clk);
      rst = rs; v0 = a0; f0 = b0; v1 = a1; f1 = b1; r0 = c0; r1 = c1; bm = bm; bad_mode = bm;
      #1;
   endtask
   initial begin
      //            rst v0 f0 v1 f1 r0 r1 rdy rv data sin busy err prdy pdata
      tbl.push_back('{1, 1, 5, 1, 3, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00});
      tbl.push_back('{1, 0, 0, 1, 7, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00});
      tbl.push_back('{0, 1, 5, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h00});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 5, 1, 0, 0, 8'h00});
      tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hFD, 5, 1, 0, 0, 8'hFD});
      tbl.push_back('{0, 0, 0, 1, 3, 0, 0, 2, 0, 8'hFD, 5, 0, 0, 2, 8'hFD});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFD, 3, 1, 0, 0, 8'hFD});
      tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 2, 8'h03, 3, 1, 0, 0, 8'h03});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 1, 0, 8'h03, 3, 0, 0, 1, 8'h03});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 0, 8'h03, 7, 1, 0, 0, 8'h03});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 1, 8'hFF, 7, 1, 0, 0, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 2, 0, 8'hFF, 7, 0, 0, 1, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 0, 8'hFF, 1, 1, 0, 0, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 2, 8'h01, 1, 1, 0, 0, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 1, 0, 8'h01, 1, 0, 0, 1, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 0, 8'h01, 7, 1, 0, 0, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 1, 8'hFF, 7, 1, 0, 0, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 2, 0, 8'hFF, 7, 0, 0, 1, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 0, 8'hFF, 1, 1, 0, 0, 8'hFF});
      tbl.push_back('{0, 1, 7, 1, 1, 1, 1, 0, 2, 8'h01, 1, 1, 0, 0, 8'hFF});
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; f0 = 3'd0; f1 = 3'd0; r0 = 1'b0; r1 = 1'b0; bad_mode = 1'b0;
      @(posedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].rst, tbl[i].v0, tbl[i].f0, tbl[i].v1, tbl[i].f1, tbl[i].r0, tbl[i].r1, 1'b0);
         chk($sformatf("row%0d ready", i), {rdy1, rdy0}, tbl[i].rdy);
         chk($sformatf("row%0d rsp_valid", i), {rv1, rv0}, tbl[i].rv);
         chk($sformatf("row%0d rsp_data", i), rsp_data, tbl[i].data);
         chk($sformatf("row%0d sext_in", i), sext_in, tbl[i].sin);
         chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
         chk($sformatf("row%0d ext_err", i), err, tbl[i].err);
         chk($sformatf("row%0d prio_ready", i), {p_rdy1, p_rdy0}, tbl[i].prdy);
         chk($sformatf("row%0d prio_data", i), p_data, tbl[i].pdata);
      end
      // response back-pressure with req1 waiting
      cyc(0, 1, 2, 0, 0, 0, 0, 0); chk("stall accept0", rdy0, 1);
      cyc(0, 0, 0, 1, 6, 0, 0, 0); chk("stall ext rdy1", rdy1, 0); chk("stall ext busy", busy, 1);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 1, 6, 0, 0, 0);
         chk($sformatf("stall%0d rv0", k), rv0, 1);
         chk($sformatf("stall%0d data", k), rsp_data, 8'h02);
         chk($sformatf("stall%0d rdy1", k), rdy1, 0);
      end
      cyc(0, 0, 0, 1, 6, 1, 0, 0); chk("release rv0", rv0, 1); chk("release rdy1", rdy1, 0);
      cyc(0, 0, 0, 1, 6, 0, 0, 0); chk("after accept1", rdy1, 1); chk("after busy", busy, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0); chk("req1 ext sext_in", sext_in, 6);
      cyc(0, 0, 0, 0, 0, 0, 1, 0); chk("req1 rv1", rv1, 1); chk("req1 data", rsp_data, 8'hFE);
      // faulty extender, sticky error, reset during RESP
      cyc(0, 1, 5, 0, 0, 0, 0, 1); chk("err accept", rdy0, 1); chk("err pre", err, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1); chk("err ext", err, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1); chk("err rv0", rv0, 1); chk("err data", rsp_data, 8'h05);
      chk("err set", err, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 0); chk("err hold resp", err, 1);
      cyc(0, 1, 5, 0, 0, 0, 0, 0); chk("err idle accept", rdy0, 1); chk("err sticky idle", err, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0); chk("good ext busy", busy, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0); chk("good rv0", rv0, 1); chk("good data", rsp_data, 8'hFD);
      chk("err sticky good", err, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0); chk("rst cycle rv0", rv0, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 0); chk("post rst rv0", rv0, 0); chk("post rst err", err, 0);
      chk("post rst data", rsp_data, 8'h00); chk("post rst busy", busy, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0); chk("post rst no rsp", rv0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
